mux_nx1_scan: RTL and testbench
===============================

# mux_nx1_scan

Parametrised N-input, W-bit registered multiplexer, the next generation of the team's 16x1 select mux. It supports a direct-select mode and an auto-scan mode. In auto-scan mode an internal sequencer walks the enabled channels in a mask and holds each one for a programmable number of samples. The selected sample is registered and presented on a valid/ready output, so the block feeds the LC4 datapath or a downstream FIFO with backpressure.

## Interface
- `NUM_CH`, default 16: number of input channels, 2..256.
- `SEL_W`, default 4: select/pointer width. Must equal $clog2(NUM_CH).
- `DATA_W`, default 8: width of each channel.
- `DWELL_W`, default 8: width of the dwell count.

Ports (clock and reset first):
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: reset, synchronous and active-low.
- `mode`  in  1: 0 = direct select, 1 = auto-scan.
- `sel`  in  SEL_W: channel select used in direct mode.
- `in`  in  NUM_CH*DATA_W: packed inputs; channel k is bits [k*DATA_W +: DATA_W].
- `ch_mask`  in  NUM_CH: scan enable per channel; bit k enables channel k.
- `dwell`  in  DWELL_W: number of samples per channel in scan mode, minus 1.
- `out_data`  out  DATA_W: registered selected sample.
- `out_ch`  out  SEL_W: channel index of `out_data`.
- `out_wrap`  out  1: marks the first sample after the scan pointer wraps.
- `out_valid`  out  1: output holds a sample.
- `out_ready`  in  1: downstream accepts the sample.

## Operation
- Load condition: `load = !out_valid || out_ready`. On `load`, the output register captures the next sample and `out_valid` goes to 1. With no `load`, all output fields hold.
- FSM states:
  - `S_DIRECT` (reset state).
  - `S_SCAN`.
  - `S_EMPTY`: scan mode with no enabled channel.
- `S_DIRECT`:
  - Each `load` captures `in[sel]`, `out_ch=sel`, `out_wrap=0`.
  - If `sel >= NUM_CH` (only possible when NUM_CH is not a power of two), it captures `out_data=0` and `out_ch=sel`.
  - `mode=1` sampled on a cycle with `load` moves to `S_SCAN`. The pointer is set to the lowest set bit of `ch_mask` and the dwell counter is set to 0. That cycle's load is still a direct sample.
  - If `ch_mask==0` at that point, the FSM moves to `S_EMPTY` instead.
- `S_SCAN`:
  - Each `load` captures `in[ptr]` and `out_ch=ptr`, then increments `dwell_cnt`.
  - When `dwell_cnt == dwell` on a load, `dwell_cnt` returns to 0 and the pointer advances.
  - The pointer advances to the next set bit of `ch_mask` above `ptr`, wrapping to the lowest set bit. The search is combinational priority logic.
  - If the new pointer is <= the old pointer, the next loaded sample carries `out_wrap=1`. With a single enabled channel, every advance wraps.
  - `ch_mask` is sampled only at advance time. A channel whose bit is cleared mid-dwell finishes its dwell. `dwell` is compared live.
  - `dwell=0` gives one sample per channel.
  - `ch_mask==0` at advance moves to `S_EMPTY`.
  - `mode=0` at a load returns to `S_DIRECT`, and that load is already a direct sample.
- `S_EMPTY`:
  - No loads occur. `out_valid` falls once the held sample is accepted.
  - A nonzero `ch_mask` restarts the scan at its lowest set bit with `dwell_cnt=0`, and the FSM moves to `S_SCAN`.
  - `mode=0` moves to `S_DIRECT`.
- A sample already held in the output register is never dropped or overwritten by a mode or mask change. It always waits for `out_ready`.

## Timing
- Reset (`rstn=0` at a rising edge): `out_data=0`, `out_ch=0`, `out_wrap=0`, `out_valid=0`, state `S_DIRECT`, `ptr=0`, `dwell_cnt=0`. Reset overrides a simultaneous load and takes effect mid-scan or mid-stall.
- Latency is 1 cycle: inputs (`in`, `sel`) sampled at edge t appear on the outputs after edge t.
- Throughput is one sample per cycle when `out_ready=1` continuously.
- While `out_valid && !out_ready`, `out_data`, `out_ch` and `out_wrap` are stable.
- `out_ready` may be high while `out_valid=0`; this has no effect.
- The first `out_valid` after reset occurs at the edge after `rstn` is released.

## Configuration
- `MUX_SCAN_EN` defined: the full scan sequencer is compiled in (`S_SCAN`, `S_EMPTY`, pointer search, dwell counter).
- `MUX_SCAN_EN` undefined:
  - Scan logic is removed and the FSM is fixed in `S_DIRECT`.
  - `mode`, `ch_mask` and `dwell` are ignored, and `out_wrap` is tied to 0.
  - The direct path, registered output and handshake are unchanged.

## Test plan
Common setup: NUM_CH=16, DATA_W=8, channel k driven with 8'h10+k, MUX_SCAN_EN defined unless stated.
- Reset: `rstn=0` for 2 cycles with `mode=1`, `out_ready=1` -> `out_valid=0`, `out_data=0`, `out_ch=0`, `out_wrap=0`. After release in direct mode with `sel=0`, the next cycle gives `out_data=8'h10`.
- Direct mode, `out_ready=1`, `sel`=5 then 15 on consecutive cycles -> `out_data` = 8'h15 (`out_ch=5`) then 8'h1F (`out_ch=15`), each 1 cycle later.
- Backpressure: direct `sel=3` loaded, then `out_ready=0` for 3 cycles while `sel=9` -> `out_data` holds 8'h13. One cycle after `out_ready=1`, `out_data=8'h19`.
- Scan: `ch_mask=16'h0085`, `dwell=1`, `out_ready=1` -> `out_ch` sequence 0,0,2,2,7,7,0,0. `out_wrap=1` only on the first ch0 sample after ch7. Repeat with `out_ready` toggling every other cycle -> same sequence, no sample lost.
- Empty/abort: in scan mode, set `ch_mask=0` -> `out_valid` falls after the last accepted sample and stays 0. Set `ch_mask=16'h0010` -> samples resume at channel 4. Pull `rstn` low for 1 cycle mid-dwell -> all outputs 0 the following cycle.
- Edge build: NUM_CH=12, SEL_W=4, `sel=13` -> `out_data=0`, `out_ch=13`. Build without MUX_SCAN_EN with `mode=1`, `sel=6` -> `out_data=8'h16`, `out_wrap=0`.

Source files
------------

// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-input registered mux, direct select or auto-scan.
// Scan sequencer is compiled in only when MUX_SCAN_EN is defined.
module mux_nx1_scan #(
  parameter int NUM_CH  = 16,
  parameter int SEL_W   = 4,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_wrap,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic              load;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] dir_data;

  logic              cap_en;
  logic              cap_wrap;
  logic              valid_nx;
  logic [DATA_W-1:0] cap_data;
  logic [SEL_W-1:0]  cap_ch;

  assign load = !out_valid || out_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_data[g] = in[g*DATA_W +: DATA_W];
  end

  // Direct pick; selects past the last channel read as zero.
  always_comb begin
    dir_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) dir_data = ch_data[k];
    end
  end

`ifdef MUX_SCAN_EN
  typedef enum logic [1:0] {
    S_DIRECT = 2'd0,
    S_SCAN   = 2'd1,
    S_EMPTY  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   ptr_nx;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_nx;
  logic               wpend;
  logic               wpend_nx;

  logic [SEL_W-1:0]   lo_idx;
  logic [SEL_W-1:0]   up_idx;
  logic               lo_any;
  logic               up_any;
  logic [SEL_W-1:0]   adv_ptr;
  logic               last;
  logic [DATA_W-1:0]  scan_data;

  // Lowest enabled channel, and lowest enabled channel above ptr.
  always_comb begin
    lo_idx = '0;
    lo_any = 1'b0;
    up_idx = '0;
    up_any = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_mask[k]) begin
        lo_idx = SEL_W'(k);
        lo_any = 1'b1;
      end
      if (ch_mask[k] && (k > int'(ptr))) begin
        up_idx = SEL_W'(k);
        up_any = 1'b1;
      end
    end
  end

  // No enabled channel above ptr means the advance wraps.
  assign adv_ptr = up_any ? up_idx : lo_idx;
  assign last    = (cnt == dwell);

  // Sample at the scan pointer.
  always_comb begin
    scan_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ptr == SEL_W'(k)) scan_data = ch_data[k];
    end
  end

  // Sequencer state, pointer, dwell counter, pending wrap flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_DIRECT;
      ptr   <= '0;
      cnt   <= '0;
      wpend <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      wpend <= wpend_nx;
    end
  end

  // Next state: mode changes act on loads, mask read at advance.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    wpend_nx = wpend;
    unique case (state)
      S_DIRECT: begin
        if (load && mode) begin
          state_nx = lo_any ? S_SCAN : S_EMPTY;
          ptr_nx   = lo_idx;
          cnt_nx   = '0;
          wpend_nx = 1'b0;
        end
      end
      S_SCAN: begin
        if (load) begin
          if (!mode) begin
            state_nx = S_DIRECT;
          end else if (!last) begin
            cnt_nx   = cnt + DWELL_W'(1);
            wpend_nx = 1'b0;
          end else begin
            cnt_nx = '0;
            if (lo_any) begin
              ptr_nx   = adv_ptr;
              wpend_nx = !up_any;
            end else begin
              state_nx = S_EMPTY;
            end
          end
        end
      end
      S_EMPTY: begin
        if (!mode) begin
          state_nx = S_DIRECT;
        end else if (lo_any) begin
          state_nx = S_SCAN;
          ptr_nx   = lo_idx;
          cnt_nx   = '0;
          wpend_nx = 1'b0;
        end
      end
      default: state_nx = S_DIRECT;
    endcase
  end

  // Output capture: direct or scan sample; empty only drains.
  always_comb begin
    cap_en   = 1'b0;
    cap_data = dir_data;
    cap_ch   = sel;
    cap_wrap = 1'b0;
    valid_nx = out_valid;
    unique case (state)
      S_DIRECT: cap_en = load;
      S_SCAN: begin
        cap_en = load;
        if (mode) begin
          cap_data = scan_data;
          cap_ch   = ptr;
          cap_wrap = wpend;
        end
      end
      S_EMPTY: valid_nx = out_valid && !out_ready;
      default: cap_en = 1'b0;
    endcase
    if (cap_en) valid_nx = 1'b1;
  end
`else
  logic unused_scan;
  assign unused_scan = ^{mode, ch_mask, dwell};

  // Direct only: every load captures, so valid stays up after it.
  always_comb begin
    cap_en   = load;
    cap_data = dir_data;
    cap_ch   = sel;
    cap_wrap = 1'b0;
    valid_nx = 1'b1;
  end
`endif

  // Output register: captures on load, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_wrap  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid_nx;
      if (cap_en) begin
        out_data <= cap_data;
        out_ch   <= cap_ch;
        out_wrap <= cap_wrap;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb_mux_nx1_scan: randomized self-checking bench for mux_nx1_scan.
// Covers direct, backpressure, scan sequencing, empty and 12-ch build.
module tb_mux_nx1_scan;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         mode;
  logic         out_ready;
  logic [3:0]   sel;
  logic [127:0] din;
  logic [15:0]  ch_mask;
  logic [7:0]   dwell;
  logic [7:0]   out_data;
  logic [3:0]   out_ch;
  logic         out_wrap;
  logic         out_valid;

  logic         mode12;
  logic         ready12;
  logic [3:0]   sel12;
  logic [95:0]  din12;
  logic [11:0]  mask12;
  logic [7:0]   dwell12;
  logic [7:0]   data12;
  logic [3:0]   ch12;
  logic         wrap12;
  logic         valid12;

  int passed = 0;
  int total  = 0;

  mux_nx1_scan u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .mode      (mode),
    .sel       (sel),
    .in        (din),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_wrap  (out_wrap),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_nx1_scan #(
    .NUM_CH  (12),
    .SEL_W   (4),
    .DATA_W  (8),
    .DWELL_W (8)
  ) u_dut12 (
    .clk       (clk),
    .rstn      (rstn),
    .mode      (mode12),
    .sel       (sel12),
    .in        (din12),
    .ch_mask   (mask12),
    .dwell     (dwell12),
    .out_data  (data12),
    .out_ch    (ch12),
    .out_wrap  (wrap12),
    .out_valid (valid12),
    .out_ready (ready12)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in_default;
    for (int k = 0; k < 16; k++) din[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 12; k++) din12[k*8 +: 8] = 8'(8'h10 + k);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    mode = 1'b1;
    out_ready = 1'b1;
    sel = 4'd0;
    tick;
    tick;
    total++;
    if ({out_valid, out_wrap, out_ch, out_data} !== 14'h0)
      $display("FAIL reset: got %h want %h",
               {out_valid, out_wrap, out_ch, out_data}, 14'h0);
    else passed++;
    rstn = 1'b1;
    mode = 1'b0;
    tick;
    total++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 4'd0, 8'h10})
      $display("FAIL reset_release: got %h want %h",
               {out_valid, out_ch, out_data}, {1'b1, 4'd0, 8'h10});
    else passed++;
  endtask

  task automatic test_direct;
    mode = 1'b0;
    out_ready = 1'b1;
    sel = 4'd5;
    tick;
    total++;
    if ({out_ch, out_wrap, out_data} !== {4'd5, 1'b0, 8'h15})
      $display("FAIL direct_5: got %h want %h",
               {out_ch, out_wrap, out_data}, {4'd5, 1'b0, 8'h15});
    else passed++;
    sel = 4'd15;
    tick;
    total++;
    if ({out_ch, out_wrap, out_data} !== {4'd15, 1'b0, 8'h1F})
      $display("FAIL direct_15: got %h want %h",
               {out_ch, out_wrap, out_data}, {4'd15, 1'b0, 8'h1F});
    else passed++;
  endtask

  task automatic test_backpressure;
    mode = 1'b0;
    out_ready = 1'b1;
    sel = 4'd3;
    tick;
    total++;
    if (out_data !== 8'h13)
      $display("FAIL bp_load: got %h want %h", out_data, 8'h13);
    else passed++;
    out_ready = 1'b0;
    sel = 4'd9;
    repeat (3) begin
      tick;
      total++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 4'd3, 8'h13})
        $display("FAIL bp_hold: got %h want %h",
                 {out_valid, out_ch, out_data}, {1'b1, 4'd3, 8'h13});
      else passed++;
    end
    out_ready = 1'b1;
    tick;
    total++;
    if ({out_ch, out_data} !== {4'd9, 8'h19})
      $display("FAIL bp_release: got %h want %h",
               {out_ch, out_data}, {4'd9, 8'h19});
    else passed++;
  endtask

  task automatic test_direct_random;
    logic       ev;
    logic [3:0] ec;
    logic [7:0] ed;
    mode = 1'b0;
    sel = 4'd0;
    out_ready = 1'b1;
    set_in_default;
    tick;
    ev = 1'b1;
    ec = 4'd0;
    ed = 8'h10;
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 4; k++) din[k*32 +: 32] = $urandom();
      sel = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
`ifndef MUX_SCAN_EN
      mode = 1'($urandom_range(0, 1));
      ch_mask = 16'($urandom());
      dwell = 8'($urandom());
`endif
      if (!ev || out_ready) begin
        ev = 1'b1;
        ec = sel;
        ed = din[int'(sel)*8 +: 8];
      end
      tick;
      total++;
      if ({out_valid, out_ch, out_wrap, out_data} !== {ev, ec, 1'b0, ed})
        $display("FAIL direct_rand: got %h want %h",
                 {out_valid, out_ch, out_wrap, out_data}, {ev, ec, 1'b0, ed});
      else passed++;
    end
    mode = 1'b0;
    out_ready = 1'b1;
    set_in_default;
    tick;
  endtask

`ifdef MUX_SCAN_EN
  task automatic run_scan(input logic [15:0] m, input int d,
                          input int rmode, input string name);
    int          ec[$];
    bit          ew[$];
    int          e;
    bit          w;
    bit          held;
    logic [13:0] prev;
    logic [13:0] got;
    logic [13:0] want;
    mode = 1'b0;
    out_ready = 1'b1;
    set_in_default;
    sel = 4'd11;
    ch_mask = m;
    dwell = 8'(d);
    tick;
    tick;
    ec.delete();
    ew.delete();
    ec.push_back(11);
    ew.push_back(1'b0);
    for (int p = 0; ec.size() < 100; p++) begin
      bit first = 1'b1;
      for (int c = 0; c < 16; c++) begin
        if (m[c]) begin
          for (int r = 0; r <= d; r++) begin
            ec.push_back(c);
            ew.push_back((p > 0) && first);
            first = 1'b0;
          end
        end
      end
    end
    mode = 1'b1;
    tick;
    held = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      got = {out_valid, out_ch, out_wrap, out_data};
      if (held) begin
        total++;
        if (got !== prev)
          $display("FAIL %s_hold: got %h want %h", name, got, prev);
        else passed++;
      end
      if (out_ready) begin
        e = ec.pop_front();
        w = ew.pop_front();
        want = {1'b1, 4'(e), w, 8'(8'h10 + e)};
        total++;
        if (got !== want)
          $display("FAIL %s: got %h want %h", name, got, want);
        else passed++;
        held = 1'b0;
      end else begin
        prev = got;
        held = 1'b1;
      end
      tick;
    end
    mode = 1'b0;
    sel = 4'd9;
    out_ready = 1'b1;
    tick;
    total++;
    if ({out_ch, out_wrap, out_data} !== {4'd9, 1'b0, 8'h19})
      $display("FAIL %s_exit: got %h want %h", name,
               {out_ch, out_wrap, out_data}, {4'd9, 1'b0, 8'h19});
    else passed++;
  endtask

  task automatic test_scan;
    logic [15:0] m;
    run_scan(16'h0085, 1, 0, "scan");
    run_scan(16'h0085, 1, 1, "scan_toggle");
    run_scan(16'h8000, 2, 2, "scan_single");
    repeat (3) begin
      m = 16'($urandom());
      if (m == 16'h0) m = 16'h0001;
      run_scan(m, $urandom_range(0, 3), 2, "scan_rand");
    end
  endtask

  task automatic test_empty;
    bit seen;
    mode = 1'b0;
    out_ready = 1'b1;
    dwell = 8'd0;
    tick;
    tick;
    ch_mask = 16'h0;
    mode = 1'b1;
    sel = 4'd2;
    tick;
    total++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 4'd2, 8'h12})
      $display("FAIL empty_entry: got %h want %h",
               {out_valid, out_ch, out_data}, {1'b1, 4'd2, 8'h12});
    else passed++;
    repeat (4) begin
      tick;
      total++;
      if (out_valid !== 1'b0)
        $display("FAIL empty_idle: got %b want 0", out_valid);
      else passed++;
    end
    ch_mask = 16'h0010;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || {out_ch, out_wrap, out_data} !== {4'd4, 1'b0, 8'h14})
      $display("FAIL restart: got %h want %h",
               {seen, out_ch, out_wrap, out_data}, {1'b1, 4'd4, 1'b0, 8'h14});
    else passed++;
    tick;
    total++;
    if ({out_valid, out_ch, out_wrap} !== {1'b1, 4'd4, 1'b1})
      $display("FAIL single_wrap: got %h want %h",
               {out_valid, out_ch, out_wrap}, {1'b1, 4'd4, 1'b1});
    else passed++;
    out_ready = 1'b0;
    ch_mask = 16'h0;
    tick;
    tick;
    total++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 4'd4, 8'h14})
      $display("FAIL empty_hold: got %h want %h",
               {out_valid, out_ch, out_data}, {1'b1, 4'd4, 8'h14});
    else passed++;
    out_ready = 1'b1;
    tick;
    total++;
    if ({out_valid, out_ch} !== {1'b1, 4'd4})
      $display("FAIL last_sample: got %h want %h",
               {out_valid, out_ch}, {1'b1, 4'd4});
    else passed++;
    repeat (4) begin
      tick;
      total++;
      if (out_valid !== 1'b0)
        $display("FAIL drain: got %b want 0", out_valid);
      else passed++;
    end
    ch_mask = 16'h0085;
    dwell = 8'd3;
    tick;
    tick;
    tick;
    total++;
    if ({out_valid, out_ch} !== {1'b1, 4'd0})
      $display("FAIL mid_dwell: got %h want %h",
               {out_valid, out_ch}, {1'b1, 4'd0});
    else passed++;
    rstn = 1'b0;
    tick;
    total++;
    if ({out_valid, out_wrap, out_ch, out_data} !== 14'h0)
      $display("FAIL rst_mid: got %h want %h",
               {out_valid, out_wrap, out_ch, out_data}, 14'h0);
    else passed++;
    rstn = 1'b1;
    mode = 1'b0;
    sel = 4'd0;
    tick;
    total++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 4'd0, 8'h10})
      $display("FAIL rst_release: got %h want %h",
               {out_valid, out_ch, out_data}, {1'b1, 4'd0, 8'h10});
    else passed++;
  endtask
`else
  task automatic test_noscan;
    mode = 1'b1;
    ch_mask = 16'hFFFF;
    dwell = 8'd0;
    sel = 4'd6;
    out_ready = 1'b1;
    tick;
    total++;
    if ({out_valid, out_ch, out_wrap, out_data} !== {1'b1, 4'd6, 1'b0, 8'h16})
      $display("FAIL noscan_6: got %h want %h",
               {out_valid, out_ch, out_wrap, out_data},
               {1'b1, 4'd6, 1'b0, 8'h16});
    else passed++;
    sel = 4'd2;
    tick;
    total++;
    if ({out_ch, out_wrap, out_data} !== {4'd2, 1'b0, 8'h12})
      $display("FAIL noscan_2: got %h want %h",
               {out_ch, out_wrap, out_data}, {4'd2, 1'b0, 8'h12});
    else passed++;
  endtask
`endif

  task automatic test_edge12;
    mode12 = 1'b0;
    ready12 = 1'b1;
    sel12 = 4'd13;
    tick;
    total++;
    if ({valid12, ch12, wrap12, data12} !== {1'b1, 4'd13, 1'b0, 8'h00})
      $display("FAIL edge12_13: got %h want %h",
               {valid12, ch12, wrap12, data12}, {1'b1, 4'd13, 1'b0, 8'h00});
    else passed++;
    sel12 = 4'd11;
    tick;
    total++;
    if ({ch12, data12} !== {4'd11, 8'h1B})
      $display("FAIL edge12_11: got %h want %h",
               {ch12, data12}, {4'd11, 8'h1B});
    else passed++;
    sel12 = 4'd15;
    tick;
    total++;
    if ({ch12, data12} !== {4'd15, 8'h00})
      $display("FAIL edge12_15: got %h want %h",
               {ch12, data12}, {4'd15, 8'h00});
    else passed++;
  endtask

  initial begin
    rstn = 1'b0;
    mode = 1'b1;
    out_ready = 1'b1;
    sel = 4'd0;
    ch_mask = 16'h0085;
    dwell = 8'd0;
    mode12 = 1'b0;
    ready12 = 1'b1;
    sel12 = 4'd0;
    mask12 = 12'h0;
    dwell12 = 8'd0;
    set_in_default;
    test_reset;
    test_direct;
    test_backpressure;
    test_direct_random;
`ifdef MUX_SCAN_EN
    test_scan;
    test_empty;
`else
    test_noscan;
`endif
    test_edge12;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
